// File: rtl/usb_cmd_resp_framer_pkg.sv
// Shared protocol constants, FSM encoding and command codes for the
// USB command-response framer.
package usb_cmd_resp_framer_pkg;

  localparam logic [7:0] PROTO_HEADER  = 8'h02;
  localparam logic [7:0] PROTO_TAIL    = 8'h03;
  localparam logic [7:0] RESERVED_BYTE = 8'h00;
  localparam int         FRAME_OVERHEAD = 13;

  // Byte offsets of each field within a frame.
  localparam int OFS_CMD  = 1;
  localparam int OFS_RSVD = 3;
  localparam int OFS_LEN  = 4;
  localparam int OFS_CSUM = 8;
  localparam int OFS_DATA = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_CSUM,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_FIN,
    ST_DONE
  } state_e;

  typedef enum logic [15:0] {
    CMD_STATUS  = 16'h0008,
    CMD_CONFIG  = 16'h003a,
    CMD_VERSION = 16'h0057
  } cmd_code_e;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] n);
    return w[{n, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/usb_rr_arbiter.sv
// Round-robin arbiter: picks the first pending channel at/after the pointer;
// the pointer moves past the winner when the grant is consumed.
module usb_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pend,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              valid
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (int'(ptr) + i) % NUM_CH;
      if (!valid && pend[cand]) begin
        valid       = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && valid) begin
      ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : IDX_W'(grant_idx + 1'b1);
    end
  end

endmodule

// File: rtl/usb_cmd_resp_framer.sv
// Multi-channel command-response framer: round-robin grant, optional payload
// checksum, byte-pop serialisation to the USB core and timeout retransmit.
module usb_cmd_resp_framer
  import usb_cmd_resp_framer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int MAX_DATA_BYTES = 16,
  parameter int LEN_W          = 7,
  parameter int CSUM_MODE      = 0,
  parameter int RETX_TIMEOUT   = 70,
  parameter int MAX_RETRY      = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                i_req,
  input  logic [NUM_CH*16-1:0]             i_cmd,
  input  logic [NUM_CH*LEN_W-1:0]          i_len,
  input  logic [NUM_CH*MAX_DATA_BYTES*8-1:0] i_data,
  input  logic                             i_txact,
  input  logic                             i_txpop,
  input  logic                             i_txpktfin_o,
  output logic [7:0]                       o_txdat,
  output logic [15:0]                      o_txdat_len,
  output logic                             o_txcork,
  output logic                             o_cmd_en,
  output logic                             tx_busy,
  output logic [NUM_CH-1:0]                o_done,
  output logic                             o_fail,
  output logic [NUM_CH-1:0]                o_drop
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(RETX_TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BUF_W = MAX_DATA_BYTES * 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_BYTES);

  state_e state, state_next;

  logic [NUM_CH-1:0] pend, pend_next, drop_vec, inflight;
  logic [NUM_CH-1:0] arb_grant, grant_oh_q;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  logic [15:0]       cmd_q;
  logic [LEN_W-1:0]  len_q, len_sel, csum_cnt;
  logic [BUF_W-1:0]  data_q;
  logic [31:0]       csum_q;
  logic [7:0]        tx_idx, sel, last_idx, nxt_byte, csum_byte;
  logic [TMR_W-1:0]  timer;
  logic [RTY_W-1:0]  retry;
  logic              fail_q, tail_pop, timeout, retry_ok, csum_last;

  usb_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .pend      (pend),
    .advance   (state == ST_ARB),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_comb begin
    len_sel = i_len[arb_idx*LEN_W +: LEN_W];
    if (len_sel > MAX_LEN) len_sel = MAX_LEN;
  end

  assign last_idx  = 8'(OFS_DATA) + 8'(len_q);
  assign tail_pop  = (state == ST_SEND) && i_txpop && (tx_idx == last_idx);
  assign timeout   = (timer == TMR_W'(RETX_TIMEOUT));
  assign retry_ok  = (retry < RTY_W'(MAX_RETRY));
  assign csum_last = (len_q == '0) || (csum_cnt == len_q - LEN_W'(1));
  assign csum_byte = data_q[{csum_cnt, 3'b000} +: 8];

  // A channel counts as busy from its grant until its DONE cycle.
  assign inflight  = (state != ST_IDLE && state != ST_ARB) ? grant_oh_q : '0;
  assign drop_vec  = i_req & (pend | inflight);
  assign pend_next = ((state == ST_ARB) ? (pend & ~arb_grant) : pend) | (i_req & ~drop_vec);

  // Byte presented after the next pop.
  always_comb begin
    sel      = tx_idx + 8'd1;
    nxt_byte = RESERVED_BYTE;
    if (sel < 8'(OFS_RSVD))
      nxt_byte = (sel == 8'(OFS_CMD)) ? cmd_q[7:0] : cmd_q[15:8];
    else if (sel == 8'(OFS_RSVD))
      nxt_byte = RESERVED_BYTE;
    else if (sel < 8'(OFS_CSUM))
      nxt_byte = word_byte(32'(len_q), 2'(sel - 8'(OFS_LEN)));
    else if (sel < 8'(OFS_DATA))
      nxt_byte = word_byte(csum_q, 2'(sel - 8'(OFS_CSUM)));
    else if (sel < last_idx)
      nxt_byte = data_q[{sel - 8'(OFS_DATA), 3'b000} +: 8];
    else
      nxt_byte = PROTO_TAIL;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (arb_valid) state_next = ST_ARB;
      ST_ARB:      state_next = ST_CSUM;
      ST_CSUM:     if (CSUM_MODE == 0 || csum_last) state_next = ST_LOAD;
      ST_LOAD:     if (!i_txact) state_next = ST_SEND;
      ST_SEND:     if (tail_pop) state_next = i_txpktfin_o ? ST_DONE : ST_WAIT_FIN;
      ST_WAIT_FIN: begin
        if (i_txpktfin_o)  state_next = ST_DONE;
        else if (timeout)  state_next = retry_ok ? ST_LOAD : ST_DONE;
      end
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: the payload buffer is pure storage, always written before it is
  // read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_ARB) data_q <= i_data[arb_idx*BUF_W +: BUF_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      grant_oh_q  <= '0;
      cmd_q       <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      csum_cnt    <= '0;
      tx_idx      <= '0;
      timer       <= '0;
      retry       <= '0;
      fail_q      <= 1'b0;
      o_txdat     <= '0;
      o_txdat_len <= '0;
      o_txcork    <= 1'b1;
      o_cmd_en    <= 1'b0;
      tx_busy     <= 1'b0;
      o_done      <= '0;
      o_fail      <= 1'b0;
      o_drop      <= '0;
    end else begin
      o_done  <= '0;
      o_fail  <= 1'b0;
      o_drop  <= drop_vec;
      tx_busy <= (state_next != ST_IDLE);
      pend    <= pend_next;
      case (state)
        ST_ARB: begin
          grant_oh_q <= arb_grant;
          cmd_q      <= i_cmd[arb_idx*16 +: 16];
          len_q      <= len_sel;
          csum_q     <= '0;
          csum_cnt   <= '0;
          fail_q     <= 1'b0;
          o_cmd_en   <= 1'b1;
        end
        ST_CSUM: begin
          if (CSUM_MODE == 0) begin
            csum_q <= 32'(len_q);
          end else if (len_q != '0) begin
            csum_q   <= csum_q + 32'(csum_byte);
            csum_cnt <= csum_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          o_txdat_len <= 16'(FRAME_OVERHEAD) + 16'(len_q);
          o_txdat     <= PROTO_HEADER;
          if (!i_txact) begin
            o_txcork <= 1'b0;
            tx_idx   <= '0;
          end
        end
        ST_SEND: begin
          if (tail_pop) begin
            o_txcork <= 1'b1;
            o_txdat  <= 8'h00;
            timer    <= '0;
          end else if (i_txpop) begin
            tx_idx  <= tx_idx + 8'd1;
            o_txdat <= nxt_byte;
          end
        end
        ST_WAIT_FIN: begin
          if (!i_txpktfin_o) begin
            if (timeout) begin
              timer <= '0;
              if (retry_ok) retry  <= retry + 1'b1;
              else          fail_q <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        ST_DONE: begin
          o_done   <= grant_oh_q;
          o_fail   <= fail_q;
          o_cmd_en <= 1'b0;
          retry    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_cmd_resp_framer.sv
// Directed bench: two framers (legacy and summing checksum) share the USB-side
// stimulus; each frame is popped byte by byte against hand-written vectors.
module tb_usb_cmd_resp_framer;

  localparam int NUM_CH = 4;
  localparam int MAXB   = 16;
  localparam int LEN_W  = 7;
  localparam int RETX   = 70;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_CH-1:0]        req0, req1;
  logic [NUM_CH*16-1:0]     cmd;
  logic [NUM_CH*LEN_W-1:0]  len;
  logic [NUM_CH*MAXB*8-1:0] data;
  logic txact, txpop, pktfin;

  logic [7:0]  txdat0, txdat1;
  logic [15:0] txlen0, txlen1;
  logic        cork0, cork1, cmden0, cmden1, busy0, busy1, fail0, fail1;
  logic [NUM_CH-1:0] done0, done1, drop0, drop1;

  logic        dsel;
  logic [7:0]  cur_txdat;
  logic [15:0] cur_txlen;
  logic        cur_cork, cur_cmden, cur_fail;
  logic [NUM_CH-1:0] cur_done;

  int n_checks = 0;
  int n_err    = 0;
  int w;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  usb_cmd_resp_framer #(.NUM_CH(NUM_CH), .MAX_DATA_BYTES(MAXB), .LEN_W(LEN_W),
    .CSUM_MODE(0), .RETX_TIMEOUT(RETX), .MAX_RETRY(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_req(req0), .i_cmd(cmd), .i_len(len), .i_data(data),
    .i_txact(txact), .i_txpop(txpop), .i_txpktfin_o(pktfin),
    .o_txdat(txdat0), .o_txdat_len(txlen0), .o_txcork(cork0), .o_cmd_en(cmden0),
    .tx_busy(busy0), .o_done(done0), .o_fail(fail0), .o_drop(drop0));

  usb_cmd_resp_framer #(.NUM_CH(NUM_CH), .MAX_DATA_BYTES(MAXB), .LEN_W(LEN_W),
    .CSUM_MODE(1), .RETX_TIMEOUT(RETX), .MAX_RETRY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_req(req1), .i_cmd(cmd), .i_len(len), .i_data(data),
    .i_txact(txact), .i_txpop(txpop), .i_txpktfin_o(pktfin),
    .o_txdat(txdat1), .o_txdat_len(txlen1), .o_txcork(cork1), .o_cmd_en(cmden1),
    .tx_busy(busy1), .o_done(done1), .o_fail(fail1), .o_drop(drop1));

  assign cur_txdat = dsel ? txdat1 : txdat0;
  assign cur_txlen = dsel ? txlen1 : txlen0;
  assign cur_cork  = dsel ? cork1  : cork0;
  assign cur_cmden = dsel ? cmden1 : cmden0;
  assign cur_done  = dsel ? done1  : done0;
  assign cur_fail  = dsel ? fail1  : fail0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit which, input logic [NUM_CH-1:0] m);
    if (which) req1 = m;
    else       req0 = m;
    tick();
    req0 = '0;
    req1 = '0;
  endtask

  task automatic fin_pulse();
    pktfin = 1'b1;
    tick();
    pktfin = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] c, input logic [LEN_W-1:0] l);
    cmd[ch*16 +: 16]      = c;
    len[ch*LEN_W +: LEN_W] = l;
  endtask

  task automatic load_exp(input int ch);
    case (ch)
      0: exp_q = '{8'h02, 8'h08, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
      1: exp_q = '{8'h02, 8'h3a, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h03};
      2: exp_q = '{8'h02, 8'h57, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02,
                   8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h03};
      default: begin
        // Requested length 20 is clamped to 16 payload bytes.
        exp_q = '{8'h02, 8'h34, 8'h12, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10,
                  8'h00, 8'h00, 8'h00};
        for (int b = 1; b <= 16; b++) exp_q.push_back(8'(b));
        exp_q.push_back(8'h03);
      end
    endcase
  endtask

  // Waits for the frame to be offered, then pops and checks every byte.
  task automatic run_frame(input string tag, input bit fin_on_tail, output int waited);
    int n = 0;
    while (cur_cork !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    waited = n;
    check({tag, "_cork_low"}, 32'(cur_cork), 32'd0);
    check({tag, "_cmd_en"}, 32'(cur_cmden), 32'd1);
    check({tag, "_txlen"}, 32'(cur_txlen), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(cur_txdat), 32'(exp_q[i]));
      txpop  = 1'b1;
      pktfin = fin_on_tail && (i == exp_q.size() - 1);
      tick();
      txpop  = 1'b0;
      pktfin = 1'b0;
    end
    check({tag, "_cork_end"}, 32'(cur_cork), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [NUM_CH-1:0] exp_done,
                           input bit exp_fail, output int waited);
    int n = 0;
    while (cur_done === '0 && n < 300) begin
      tick();
      n++;
    end
    waited = n;
    check({tag, "_done"}, 32'(cur_done), 32'(exp_done));
    check({tag, "_fail"}, 32'(cur_fail), 32'(exp_fail));
    check({tag, "_cmd_en_off"}, 32'(cur_cmden), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req0 = '0; req1 = '0; cmd = '0; len = '0; data = '0;
    txact = 1'b0; txpop = 1'b0; pktfin = 1'b0; dsel = 1'b0;
    tick();
    tick();

    check("rst_txdat", 32'(txdat0), 32'd0);
    check("rst_txlen", 32'(txlen0), 32'd0);
    check("rst_cork", 32'(cork0), 32'd1);
    check("rst_cmd_en", 32'(cmden0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_fail", 32'(fail0), 32'd0);
    check("rst_drop", 32'(drop0), 32'd0);
    check("rst_cork_sum", 32'(cork1), 32'd1);
    rst_n = 1'b1;

    set_ch(0, 16'h0008, 7'd4);
    set_ch(1, 16'h003a, 7'd0);
    set_ch(2, 16'h0057, 7'd2);
    set_ch(3, 16'h1234, 7'd20);
    data[(2*MAXB + 0)*8 +: 8] = 8'h11;
    data[(2*MAXB + 1)*8 +: 8] = 8'h22;
    for (int b = 0; b < MAXB; b++) data[(3*MAXB + b)*8 +: 8] = 8'(b + 1);
    tick();

    // Legacy checksum frame, completion signalled after the tail.
    pulse(0, 4'b0001);
    load_exp(0);
    run_frame("t1", 1'b0, w);
    check("t1_waitfin_busy", 32'(busy0), 32'd1);
    check("t1_waitfin_cmd_en", 32'(cmden0), 32'd1);
    repeat (3) tick();
    fin_pulse();
    wait_done("t1", 4'b0001, 1'b0, w);

    // Pointer sits at ch1 after ch0's grant; repeat request on ch1 is dropped.
    req0 = 4'b0011;
    tick();
    req0 = 4'b0010;
    tick();
    req0 = '0;
    check("t3_drop", 32'(drop0), 32'b0010);
    tick();
    check("t3_drop_clear", 32'(drop0), 32'd0);
    load_exp(1);
    run_frame("t3_ch1", 1'b1, w);
    wait_done("t3_ch1", 4'b0010, 1'b0, w);
    load_exp(0);
    run_frame("t3_ch0", 1'b1, w);
    wait_done("t3_ch0", 4'b0001, 1'b0, w);

    // Core busy holds LOAD; packet-finish with the tail pop skips WAIT_FIN.
    txact = 1'b1;
    pulse(0, 4'b0100);
    repeat (8) tick();
    check("t5_hold_cork", 32'(cork0), 32'd1);
    check("t5_hold_busy", 32'(busy0), 32'd1);
    check("t5_hold_hdr", 32'(txdat0), 32'h02);
    txact = 1'b0;
    load_exp(2);
    run_frame("t5", 1'b1, w);
    check("t5_done_state_busy", 32'(busy0), 32'd1);
    tick();
    check("t5_done", 32'(done0), 32'b0100);
    check("t5_fail", 32'(fail0), 32'd0);
    check("t5_cmd_en", 32'(cmden0), 32'd0);
    check("t5_idle", 32'(busy0), 32'd0);

    // No packet-finish: tail pop -> WAIT_FIN (timer 0..70) -> LOAD -> header,
    // i.e. RETX+2 cycles; three retransmits, then the fourth timeout fails.
    pulse(0, 4'b0010);
    load_exp(1);
    run_frame("t4_tx0", 1'b0, w);
    for (int r = 1; r <= 3; r++) begin
      run_frame($sformatf("t4_rtx%0d", r), 1'b0, w);
      check($sformatf("t4_gap%0d", r), 32'(w), 32'(RETX + 2));
    end
    wait_done("t4", 4'b0010, 1'b1, w);
    check("t4_fail_gap", 32'(w), 32'(RETX + 2));

    // Asynchronous reset in the middle of a frame aborts it.
    pulse(0, 4'b0001);
    w = 0;
    while (cork0 !== 1'b0 && w < 100) begin
      tick();
      w++;
    end
    txpop = 1'b1;
    repeat (5) tick();
    txpop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_cork", 32'(cork0), 32'd1);
    check("t6_cmd_en", 32'(cmden0), 32'd0);
    check("t6_busy", 32'(busy0), 32'd0);
    check("t6_txdat", 32'(txdat0), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_no_done", 32'(done0), 32'd0);
    pulse(0, 4'b1000);
    load_exp(3);
    run_frame("t6_ch3", 1'b0, w);
    fin_pulse();
    wait_done("t6_ch3", 4'b1000, 1'b0, w);

    // Pointer wrapped to ch0 after ch3: simultaneous ch0/ch2 -> ch0 first.
    pulse(0, 4'b0101);
    load_exp(0);
    run_frame("t3b_ch0", 1'b1, w);
    wait_done("t3b_ch0", 4'b0001, 1'b0, w);
    load_exp(2);
    run_frame("t3b_ch2", 1'b1, w);
    wait_done("t3b_ch2", 4'b0100, 1'b0, w);

    // Summing checksum: 01+02+03+FF = 0x105; empty payload sums to zero.
    dsel = 1'b1;
    data[0 +: 32] = 32'hFF03_0201;
    pulse(1, 4'b0001);
    exp_q = '{8'h02, 8'h08, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05,
              8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'hff, 8'h03};
    run_frame("t2_sum", 1'b1, w);
    wait_done("t2_sum", 4'b0001, 1'b0, w);
    pulse(1, 4'b0010);
    exp_q = '{8'h02, 8'h3a, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h03};
    run_frame("t2_len0", 1'b1, w);
    wait_done("t2_len0", 4'b0010, 1'b0, w);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
